// File: rtl/load_agu_pipe_pkg.sv
// +------------------------------------------------------------------+
// | load_agu_pipe_pkg                                                |
// | Shared types and encodings for the load address-generation pipe. |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

package load_agu_pipe_pkg;

  localparam int ISSUE_IDX_W_DEF = 4;
  localparam int ROB_W_DEF       = 6;
  localparam int LQ_IDX_W        = 5;

  // ROB pointer: flag toggles on every wrap of value
  typedef struct packed {
    logic                 flag;
    logic [ROB_W_DEF-1:0] value;
  } RobIdx;

  typedef struct packed {
    logic [11:0]                imm;
    logic [1:0]                 size;
    logic [LQ_IDX_W-1:0]        lqIdx;
    RobIdx                      robIdx;
    logic [ISSUE_IDX_W_DEF-1:0] issue_idx;
    logic                       exception;
  } LoadIssueData;

  typedef struct packed {
    logic                       en;
    logic [1:0]                 reason;
    logic [ISSUE_IDX_W_DEF-1:0] issue_idx;
  } ReplyRequest;

  localparam logic [1:0] C_EXC_NONE       = 2'b00;
  localparam logic [1:0] C_EXC_MISALIGNED = 2'b01;
  localparam logic [1:0] C_EXC_PAGE_FAULT = 2'b10;
  localparam logic [1:0] C_EXC_UPSTREAM   = 2'b11;

  localparam logic [1:0] C_REPLY_DC_BUSY  = 2'b00;
  localparam logic [1:0] C_REPLY_TLB_MISS = 2'b11;

  localparam logic [1:0] C_SIZE_H = 2'b01;
  localparam logic [1:0] C_SIZE_W = 2'b10;

  // Halfwords need bit 0 clear, words need bits 1:0 clear
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    return ((size == C_SIZE_W) && (lsb != 2'b00)) || ((size == C_SIZE_H) && lsb[0]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_redirect_cmp.sv
// +------------------------------------------------------------------+
// | load_redirect_cmp                                                |
// | Flags a load as killed when a redirect targets an older ROB entry|
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module load_redirect_cmp #(
  parameter int ROB_W = 6
) (
  input  logic             redirect,
  input  logic             redirect_flag,
  input  logic [ROB_W-1:0] redirect_value,
  input  logic             rob_flag,
  input  logic [ROB_W-1:0] rob_value,
  output logic             kill
);

  // Younger: same wrap phase with larger index, or opposite phase with smaller index.
  // Equal pointers are the redirecting instruction itself and survive.
  assign kill = redirect &
                (((rob_flag == redirect_flag) & (rob_value > redirect_value)) |
                 ((rob_flag != redirect_flag) & (rob_value < redirect_value)));

endmodule

`default_nettype wire

// File: rtl/load_agu_pipe.sv
// +------------------------------------------------------------------+
// | load_agu_pipe                                                    |
// | Three-stage load pipe: AGU (S0), TLB/DCache issue (S1), outcome  |
// | register (S2) with redirect flush and replay accounting.         |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module load_agu_pipe
  import load_agu_pipe_pkg::*;
#(
  parameter int ISSUE_IDX_W = ISSUE_IDX_W_DEF,
  parameter int ROB_W       = ROB_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_en,
  input  LoadIssueData           in_data,
  input  logic [31:0]            rs1_data,
  input  logic                   redirect,
  input  RobIdx                  redirect_idx,
  output logic                   tlb_req_en,
  output logic [31:0]            tlb_vaddr,
  input  logic                   tlb_hit,
  input  logic                   tlb_miss,
  input  logic                   tlb_pf,
  input  logic [31:0]            tlb_paddr,
  input  logic                   dc_ready,
  output logic                   dc_req_en,
  output logic [31:0]            dc_paddr,
  output ReplyRequest            reply_fast,
  output ReplyRequest            reply_slow,
  output logic                   success,
  output logic [ISSUE_IDX_W-1:0] success_idx,
  output logic                   exc_en,
  output logic [1:0]             exc_cause,
  output logic [15:0]            replay_cnt
);

  logic [31:0]            w_s0_vaddr;
  logic                   w_kill_s0, w_kill_s1, w_kill_s2;

  logic                   r_s1_valid;
  logic [31:0]            r_s1_vaddr;
  logic                   r_s1_misaligned;
  logic                   r_s1_exception;
  logic [ISSUE_IDX_W-1:0] r_s1_issue_idx;
  RobIdx                  r_s1_rob;

  logic                   w_s1_live;
  logic                   w_s1_succ, w_s1_exc, w_s1_fast, w_s1_slow;
  logic [1:0]             w_s1_cause, w_s1_reason;

  logic                   r_s2_valid;
  logic                   r_s2_succ, r_s2_exc, r_s2_fast, r_s2_slow;
  logic [1:0]             r_s2_cause, r_s2_reason;
  logic [ISSUE_IDX_W-1:0] r_s2_issue_idx;
  RobIdx                  r_s2_rob;
  logic                   w_s2_live;

  logic [15:0]            r_replay_cnt;
  logic                   w_unused;

  // lqIdx travels with the load for the queue but this pipe never needs it;
  // tlb_hit is implied once miss and page fault are excluded
  assign w_unused = ^{in_data.lqIdx, tlb_hit};

  // ---------------- S0: address generation ----------------
  assign w_s0_vaddr = rs1_data + {{20{in_data.imm[11]}}, in_data.imm};

  load_redirect_cmp #(.ROB_W(ROB_W)) u_cmp_s0 (
    .redirect(redirect), .redirect_flag(redirect_idx.flag), .redirect_value(redirect_idx.value),
    .rob_flag(in_data.robIdx.flag), .rob_value(in_data.robIdx.value), .kill(w_kill_s0)
  );

  // S1 valid: a new load enters every cycle unless flushed on its way in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_s1_valid <= 1'b0;
    else     r_s1_valid <= in_en & ~w_kill_s0;
  end

  // S1 payload, meaningful only while r_s1_valid is set
  always_ff @(posedge clk) begin
    if (in_en) begin
      r_s1_vaddr      <= w_s0_vaddr;
      r_s1_misaligned <= is_misaligned(in_data.size, w_s0_vaddr[1:0]);
      r_s1_exception  <= in_data.exception;
      r_s1_issue_idx  <= in_data.issue_idx;
      r_s1_rob        <= in_data.robIdx;
    end
  end

  // ---------------- S1: TLB lookup and DCache issue ----------------
  load_redirect_cmp #(.ROB_W(ROB_W)) u_cmp_s1 (
    .redirect(redirect), .redirect_flag(redirect_idx.flag), .redirect_value(redirect_idx.value),
    .rob_flag(r_s1_rob.flag), .rob_value(r_s1_rob.value), .kill(w_kill_s1)
  );

  assign w_s1_live  = r_s1_valid & ~w_kill_s1;
  assign tlb_req_en = r_s1_valid & ~r_s1_misaligned & ~r_s1_exception;
  assign tlb_vaddr  = r_s1_vaddr;
  assign dc_paddr   = tlb_paddr;

  // Resolve exactly one outcome per live S1 load, in priority order
  always_comb begin
    w_s1_succ   = 1'b0;
    w_s1_exc    = 1'b0;
    w_s1_cause  = C_EXC_NONE;
    w_s1_fast   = 1'b0;
    w_s1_slow   = 1'b0;
    w_s1_reason = C_REPLY_DC_BUSY;
    dc_req_en   = 1'b0;
    if (w_s1_live) begin
      if (r_s1_exception) begin
        w_s1_exc = 1'b1; w_s1_cause = C_EXC_UPSTREAM; w_s1_succ = 1'b1;
      end else if (r_s1_misaligned) begin
        w_s1_exc = 1'b1; w_s1_cause = C_EXC_MISALIGNED; w_s1_succ = 1'b1;
      end else if (tlb_miss) begin
        w_s1_slow = 1'b1; w_s1_reason = C_REPLY_TLB_MISS;
      end else if (tlb_pf) begin
        w_s1_exc = 1'b1; w_s1_cause = C_EXC_PAGE_FAULT; w_s1_succ = 1'b1;
      end else if (!dc_ready) begin
        w_s1_fast = 1'b1; w_s1_reason = C_REPLY_DC_BUSY;
      end else begin
        dc_req_en = 1'b1;
      end
    end
  end

  // ---------------- S2: registered outcome ----------------
  // An accepted DCache request completes here, so it shares the outcome register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid     <= 1'b0;
      r_s2_succ      <= 1'b0;
      r_s2_exc       <= 1'b0;
      r_s2_fast      <= 1'b0;
      r_s2_slow      <= 1'b0;
      r_s2_cause     <= C_EXC_NONE;
      r_s2_reason    <= C_REPLY_DC_BUSY;
      r_s2_issue_idx <= '0;
      r_s2_rob       <= '0;
    end else begin
      r_s2_valid     <= w_s1_live;
      r_s2_succ      <= w_s1_succ | dc_req_en;
      r_s2_exc       <= w_s1_exc;
      r_s2_fast      <= w_s1_fast;
      r_s2_slow      <= w_s1_slow;
      r_s2_cause     <= w_s1_cause;
      r_s2_reason    <= w_s1_reason;
      r_s2_issue_idx <= r_s1_issue_idx;
      r_s2_rob       <= r_s1_rob;
    end
  end

  load_redirect_cmp #(.ROB_W(ROB_W)) u_cmp_s2 (
    .redirect(redirect), .redirect_flag(redirect_idx.flag), .redirect_value(redirect_idx.value),
    .rob_flag(r_s2_rob.flag), .rob_value(r_s2_rob.value), .kill(w_kill_s2)
  );

  // A redirect arriving while the outcome is presented still cancels it
  assign w_s2_live   = r_s2_valid & ~w_kill_s2;
  assign success     = w_s2_live & r_s2_succ;
  assign success_idx = r_s2_issue_idx;
  assign exc_en      = w_s2_live & r_s2_exc;
  assign exc_cause   = r_s2_cause;

  assign reply_fast  = '{en: w_s2_live & r_s2_fast, reason: r_s2_reason, issue_idx: r_s2_issue_idx};
  assign reply_slow  = '{en: w_s2_live & r_s2_slow, reason: r_s2_reason, issue_idx: r_s2_issue_idx};

  // Saturating count of replies actually delivered
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_replay_cnt <= '0;
    else if ((reply_fast.en | reply_slow.en) && (r_replay_cnt != 16'hFFFF))
      r_replay_cnt <= r_replay_cnt + 16'd1;
  end

  assign replay_cnt = r_replay_cnt;

endmodule

`default_nettype wire

// File: tb/tb_load_agu_pipe.sv
// +------------------------------------------------------------------+
// | tb_load_agu_pipe                                                 |
// | Scoreboard bench for load_agu_pipe.                              |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module tb_load_agu_pipe;
  import load_agu_pipe_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_en;
  LoadIssueData in_data;
  logic [31:0]  rs1_data;
  logic         redirect;
  RobIdx        redirect_idx;
  logic         tlb_req_en;
  logic [31:0]  tlb_vaddr;
  logic         tlb_hit, tlb_miss, tlb_pf;
  logic [31:0]  tlb_paddr;
  logic         dc_ready;
  logic         dc_req_en;
  logic [31:0]  dc_paddr;
  ReplyRequest  reply_fast, reply_slow;
  logic         success;
  logic [3:0]   success_idx;
  logic         exc_en;
  logic [1:0]   exc_cause;
  logic [15:0]  replay_cnt;

  load_agu_pipe #(.ISSUE_IDX_W(4), .ROB_W(6)) dut (
    .clk(clk), .rst(rst), .in_en(in_en), .in_data(in_data), .rs1_data(rs1_data),
    .redirect(redirect), .redirect_idx(redirect_idx),
    .tlb_req_en(tlb_req_en), .tlb_vaddr(tlb_vaddr),
    .tlb_hit(tlb_hit), .tlb_miss(tlb_miss), .tlb_pf(tlb_pf), .tlb_paddr(tlb_paddr),
    .dc_ready(dc_ready), .dc_req_en(dc_req_en), .dc_paddr(dc_paddr),
    .reply_fast(reply_fast), .reply_slow(reply_slow),
    .success(success), .success_idx(success_idx),
    .exc_en(exc_en), .exc_cause(exc_cause), .replay_cnt(replay_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] paddr;
    logic        hit, miss, pf, dcr;
  } resp_t;

  typedef struct {
    int         cyc;
    logic       succ, exc, fast, slow;
    logic [1:0] cause, reason;
    logic [3:0] idx;
  } exp_t;

  exp_t  sb[$];
  resp_t pending;
  logic  mon_en;
  logic  snap_dc_req;
  logic [31:0] snap_dc_paddr;
  int    n_vec  = 0;
  int    n_miss = 0;

  localparam resp_t R_NONE = '{paddr: 32'h0, hit: 1'b0, miss: 1'b0, pf: 1'b0, dcr: 1'b0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference outcome of a load, straight from the priority list
  function automatic exp_t model(input int c, input logic [31:0] rs1, input logic [11:0] imm,
                                 input logic [1:0] size, input logic exc, input resp_t r,
                                 input logic [3:0] idx);
    exp_t e;
    logic [31:0] va;
    logic mis;
    va  = rs1 + {{20{imm[11]}}, imm};
    mis = ((size == 2'b10) && (va[1:0] != 2'b00)) || ((size == 2'b01) && va[0]);
    e = '{cyc: c, succ: 1'b0, exc: 1'b0, fast: 1'b0, slow: 1'b0, cause: 2'b00, reason: 2'b00, idx: idx};
    if (exc)          begin e.exc = 1'b1; e.cause = 2'b11; e.succ = 1'b1; end
    else if (mis)     begin e.exc = 1'b1; e.cause = 2'b01; e.succ = 1'b1; end
    else if (r.miss)  begin e.slow = 1'b1; e.reason = 2'b11; end
    else if (r.pf)    begin e.exc = 1'b1; e.cause = 2'b10; e.succ = 1'b1; end
    else if (!r.dcr)  begin e.fast = 1'b1; e.reason = 2'b00; end
    else              e.succ = 1'b1;
    return e;
  endfunction

  // One cycle: present a load at S0 and the TLB/DCache response for the load in S1
  task automatic step(input logic en, input logic [31:0] rs1, input logic [11:0] imm,
                      input logic [1:0] size, input logic [3:0] idx, input logic rflag,
                      input logic [5:0] rval, input logic exc, input resp_t resp,
                      input logic expect_out);
    in_en                 = en;
    rs1_data              = rs1;
    in_data.imm           = imm;
    in_data.size          = size;
    in_data.lqIdx         = {1'b0, idx};
    in_data.robIdx.flag   = rflag;
    in_data.robIdx.value  = rval;
    in_data.issue_idx     = idx;
    in_data.exception     = exc;
    tlb_paddr = pending.paddr;
    tlb_hit   = pending.hit;
    tlb_miss  = pending.miss;
    tlb_pf    = pending.pf;
    dc_ready  = pending.dcr;
    pending   = en ? resp : R_NONE;
    if (en && expect_out) sb.push_back(model(cyc + 2, rs1, imm, size, exc, resp, idx));
    #2;
    snap_dc_req   = dc_req_en;
    snap_dc_paddr = dc_paddr;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 12'h0, 2'b00, 4'h0, 1'b0, 6'h0, 1'b0, R_NONE, 1'b0);
  endtask

  // Scoreboard side: every outcome the DUT presents must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !rst) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        check("missing_outcome_cycle", cyc, sb[0].cyc);
        sb.delete(0);
      end
      if (success || reply_fast.en || reply_slow.en || exc_en) begin
        check("outcome_mutex", 32'($countones({success, reply_fast.en, reply_slow.en})), 32'd1);
        if (sb.size() == 0) begin
          check("unexpected_outcome", {28'd0, success, reply_fast.en, reply_slow.en, exc_en}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("outcome_cycle", cyc, e.cyc);
          check("success", success, e.succ);
          check("exc_en", exc_en, e.exc);
          check("reply_fast_en", reply_fast.en, e.fast);
          check("reply_slow_en", reply_slow.en, e.slow);
          if (e.exc)  check("exc_cause", exc_cause, e.cause);
          if (e.succ) check("success_idx", success_idx, e.idx);
          if (e.fast) begin
            check("fast_reason", reply_fast.reason, e.reason);
            check("fast_idx", reply_fast.issue_idx, e.idx);
          end
          if (e.slow) begin
            check("slow_reason", reply_slow.reason, e.reason);
            check("slow_idx", reply_slow.issue_idx, e.idx);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_en = 1'b0; in_data = '0; rs1_data = '0; redirect = 1'b0; redirect_idx = '0;
    tlb_hit = 1'b0; tlb_miss = 1'b0; tlb_pf = 1'b0; tlb_paddr = '0; dc_ready = 1'b0;
    pending = R_NONE; mon_en = 1'b1; snap_dc_req = 1'b0; snap_dc_paddr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tlb_req_en", tlb_req_en, 1'b0);
    check("rst_dc_req_en", dc_req_en, 1'b0);
    check("rst_success", success, 1'b0);
    check("rst_success_idx", success_idx, 4'h0);
    check("rst_exc_en", exc_en, 1'b0);
    check("rst_exc_cause", exc_cause, 2'b00);
    check("rst_reply_fast", reply_fast, '0);
    check("rst_reply_slow", reply_slow, '0);
    check("rst_replay_cnt", replay_cnt, 16'h0);
    rst = 1'b0;
    idle();

    // Aligned word hit
    step(1'b1, 32'h1000, 12'h004, 2'b10, 4'h3, 1'b0, 6'd1, 1'b0,
         '{paddr: 32'h8000_1004, hit: 1'b1, miss: 1'b0, pf: 1'b0, dcr: 1'b1}, 1'b1);
    check("hit_tlb_vaddr", tlb_vaddr, 32'h0000_1004);
    check("hit_tlb_req_en", tlb_req_en, 1'b1);
    idle();
    check("hit_dc_req_en", snap_dc_req, 1'b1);
    check("hit_dc_paddr", snap_dc_paddr, 32'h8000_1004);
    repeat (3) idle();

    // Misaligned halfword: no TLB lookup, exception + success
    step(1'b1, 32'h1001, 12'h000, 2'b01, 4'h5, 1'b0, 6'd2, 1'b0, R_NONE, 1'b1);
    check("mis_tlb_req_en", tlb_req_en, 1'b0);
    idle();
    check("mis_dc_req_en", snap_dc_req, 1'b0);
    repeat (3) idle();

    // TLB miss then DCache busy
    step(1'b1, 32'h2000, 12'h010, 2'b10, 4'h6, 1'b0, 6'd2, 1'b0,
         '{paddr: 32'h0, hit: 1'b0, miss: 1'b1, pf: 1'b0, dcr: 1'b1}, 1'b1);
    step(1'b1, 32'h2000, 12'h020, 2'b10, 4'h7, 1'b0, 6'd3, 1'b0,
         '{paddr: 32'h9000_0020, hit: 1'b1, miss: 1'b0, pf: 1'b0, dcr: 1'b0}, 1'b1);
    repeat (4) idle();
    check("replay_cnt_two", replay_cnt, 16'd2);

    // Upstream exception and page fault
    step(1'b1, 32'h3000, 12'h000, 2'b10, 4'h1, 1'b0, 6'd4, 1'b1,
         '{paddr: 32'h0, hit: 1'b1, miss: 1'b0, pf: 1'b0, dcr: 1'b1}, 1'b1);
    step(1'b1, 32'h3000, 12'h008, 2'b10, 4'h2, 1'b0, 6'd4, 1'b0,
         '{paddr: 32'h0, hit: 1'b0, miss: 1'b0, pf: 1'b1, dcr: 1'b1}, 1'b1);
    repeat (3) idle();

    // Redirect to rob 6: rob 5 in S1 survives, rob 7 in S0 dies
    step(1'b1, 32'h4000, 12'h000, 2'b10, 4'h8, 1'b0, 6'd5, 1'b0,
         '{paddr: 32'hA000_4000, hit: 1'b1, miss: 1'b0, pf: 1'b0, dcr: 1'b1}, 1'b1);
    redirect = 1'b1; redirect_idx = '{flag: 1'b0, value: 6'd6};
    step(1'b1, 32'h4000, 12'h004, 2'b10, 4'h9, 1'b0, 6'd7, 1'b0,
         '{paddr: 32'hA000_4004, hit: 1'b1, miss: 1'b0, pf: 1'b0, dcr: 1'b1}, 1'b0);
    check("redir_older_dc_req", snap_dc_req, 1'b1);
    redirect = 1'b0;
    idle();
    check("redir_younger_dc_req", snap_dc_req, 1'b0);
    repeat (3) idle();

    // Address wrap-around and negative offset
    step(1'b1, 32'hFFFF_FFFC, 12'h008, 2'b10, 4'hA, 1'b0, 6'd8, 1'b0,
         '{paddr: 32'h0000_0004, hit: 1'b1, miss: 1'b0, pf: 1'b0, dcr: 1'b1}, 1'b1);
    check("wrap_tlb_vaddr", tlb_vaddr, 32'h0000_0004);
    step(1'b1, 32'h0000_0100, 12'hFFC, 2'b10, 4'hB, 1'b0, 6'd9, 1'b0,
         '{paddr: 32'h0000_00FC, hit: 1'b1, miss: 1'b0, pf: 1'b0, dcr: 1'b1}, 1'b1);
    check("negimm_tlb_vaddr", tlb_vaddr, 32'h0000_00FC);
    repeat (3) idle();

    // Opposite-phase redirect {0,10}: {1,12} is older and survives, {1,3} is younger and dies
    step(1'b1, 32'h5000, 12'h000, 2'b10, 4'hA, 1'b1, 6'd12, 1'b0,
         '{paddr: 32'hB000_0000, hit: 1'b1, miss: 1'b0, pf: 1'b0, dcr: 1'b1}, 1'b1);
    redirect = 1'b1; redirect_idx = '{flag: 1'b0, value: 6'd10};
    step(1'b1, 32'h5000, 12'h004, 2'b10, 4'hB, 1'b1, 6'd3, 1'b0,
         '{paddr: 32'hB000_0004, hit: 1'b1, miss: 1'b0, pf: 1'b0, dcr: 1'b1}, 1'b0);
    check("dirdiff_older_dc_req", snap_dc_req, 1'b1);
    redirect = 1'b0;
    idle();
    check("dirdiff_younger_dc_req", snap_dc_req, 1'b0);
    repeat (3) idle();

    // Same-phase younger load killed in S1 while the redirecting load itself survives in S0
    step(1'b1, 32'h6000, 12'h000, 2'b10, 4'hC, 1'b0, 6'd12, 1'b0,
         '{paddr: 32'hC000_0000, hit: 1'b1, miss: 1'b0, pf: 1'b0, dcr: 1'b1}, 1'b0);
    redirect = 1'b1; redirect_idx = '{flag: 1'b0, value: 6'd10};
    step(1'b1, 32'h6000, 12'h004, 2'b10, 4'hD, 1'b0, 6'd10, 1'b0,
         '{paddr: 32'hC000_0004, hit: 1'b1, miss: 1'b0, pf: 1'b0, dcr: 1'b1}, 1'b1);
    check("s1_kill_dc_req", snap_dc_req, 1'b0);
    redirect = 1'b0;
    idle();
    check("self_survive_dc_req", snap_dc_req, 1'b1);
    repeat (3) idle();

    // Outcome already in S2 cancelled by a redirect arriving that cycle
    step(1'b1, 32'h7000, 12'h000, 2'b10, 4'hE, 1'b0, 6'd20, 1'b0,
         '{paddr: 32'hD000_0000, hit: 1'b1, miss: 1'b0, pf: 1'b0, dcr: 1'b1}, 1'b0);
    idle();
    redirect = 1'b1; redirect_idx = '{flag: 1'b0, value: 6'd15};
    idle();
    redirect = 1'b0;
    repeat (3) idle();

    // Reset asserted while a load sits in S1
    step(1'b1, 32'h8000, 12'h000, 2'b10, 4'hF, 1'b0, 6'd30, 1'b0,
         '{paddr: 32'hE000_0000, hit: 1'b1, miss: 1'b0, pf: 1'b0, dcr: 1'b1}, 1'b0);
    in_en = 1'b0;
    tlb_hit = 1'b1; dc_ready = 1'b1; tlb_paddr = 32'hE000_0000;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_tlb_req_en", tlb_req_en, 1'b0);
    check("midrst_dc_req_en", dc_req_en, 1'b0);
    check("midrst_success", success, 1'b0);
    check("midrst_replay_cnt", replay_cnt, 16'h0);
    pending = R_NONE;
    tlb_hit = 1'b0; dc_ready = 1'b0; tlb_paddr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) idle();
    check("sb_drained", sb.size(), 32'd0);

    // Replay counter saturation: one TLB miss per cycle
    mon_en = 1'b0;
    in_data = '0; rs1_data = 32'h100; in_en = 1'b1;
    tlb_hit = 1'b0; tlb_miss = 1'b1; tlb_pf = 1'b0; dc_ready = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    in_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("replay_cnt_saturated", replay_cnt, 16'hFFFF);
    in_en = 1'b1;
    @(posedge clk); #1;
    in_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("replay_cnt_held", replay_cnt, 16'hFFFF);
    tlb_miss = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
